// File: rtl/reg_file_loader_pkg.sv
// Shared definitions for the register-file write loader: parser states,
// header field positions and the register word width.
package reg_file_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOW   = 3'd1,
      HIGH  = 3'd2,
      WRITE = 3'd3,
      DRAIN = 3'd4
   } state_t;

   localparam int HDR_ADDR_LSB = 0;
   localparam int HDR_ADDR_MSB = 3;
   localparam int HDR_CNT_LSB  = 4;
   localparam int HDR_CNT_MSB  = 7;
   localparam int WORD_W       = 16;

endpackage

// File: rtl/reg_file_loader_addr_ctr.sv
// Loadable modulo-NUM_REGS address counter; o_wrap flags the last entry so
// the next increment returns to 0 even when NUM_REGS is not a power of two.
module reg_file_loader_addr_ctr #(
   parameter int NUM_REGS = 2,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_load_addr,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_wrap
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

   logic [ADDR_W-1:0] r_addr;

   assign o_wrap = (r_addr == LAST_ADDR);
   assign o_addr = r_addr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_addr <= '0;
      end else if (i_load) begin
         r_addr <= i_load_addr;
      end else if (i_inc) begin
         r_addr <= o_wrap ? '0 : r_addr + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/reg_file_loader.sv
// Byte-stream frame parser that assembles 16-bit words and drives the
// register-file write port with auto-incrementing, wrapping addresses.
module reg_file_loader
   import reg_file_loader_pkg::*;
#(
   parameter int NUM_REGS = 2,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              reset,
   input  logic              clock,
   input  logic              byte_valid,
   input  logic [7:0]        byte_in,
   output logic              byte_ready,
   output logic              wen_out,
   output logic [ADDR_W-1:0] waddr_out,
   output logic [WORD_W-1:0] d_out,
   output logic              busy,
   output logic              frame_done,
   output logic              err
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_ready;
   logic [3:0]          r_word_cnt;
   logic [5:0]          r_drain_cnt;
   logic [7:0]          r_lo_byte;
   logic [WORD_W-1:0]   r_d_out;
   logic [ADDR_W-1:0]   r_waddr;
   logic                r_wen;
   logic                r_done;
   logic                r_err;

   logic                w_accept;
   logic [3:0]          w_hdr_addr;
   logic [3:0]          w_hdr_cnt;
   logic                w_hdr_ok;
   logic                w_ctr_load;
   logic                w_ctr_inc;
   logic [ADDR_W-1:0]   w_ctr_addr;
   logic                w_addr_wrap;
   logic                w_wen_nxt;
   logic                w_done_nxt;
   logic                w_err_nxt;

   assign w_accept   = byte_valid && r_ready;
   assign w_hdr_addr = byte_in[HDR_ADDR_MSB:HDR_ADDR_LSB];
   assign w_hdr_cnt  = byte_in[HDR_CNT_MSB:HDR_CNT_LSB];
   assign w_hdr_ok   = ({1'b0, w_hdr_addr} < 5'(NUM_REGS));

   reg_file_loader_addr_ctr #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_addr_ctr (
      .clock       (clock),
      .reset       (reset),
      .i_load      (w_ctr_load),
      .i_load_addr (w_hdr_addr[ADDR_W-1:0]),
      .i_inc       (w_ctr_inc),
      .o_addr      (w_ctr_addr),
      .o_wrap      (w_addr_wrap)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_ctr_load  = 1'b0;
      w_ctr_inc   = 1'b0;
      w_wen_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_hdr_ok) begin
                  w_ctr_load  = 1'b1;
                  w_state_nxt = LOW;
               end else begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = DRAIN;
               end
            end
         end
         LOW: begin
            if (w_accept) w_state_nxt = HIGH;
         end
         HIGH: begin
            // The write is registered here so wen_out lands on the WRITE cycle.
            if (w_accept) begin
               w_state_nxt = WRITE;
               w_wen_nxt   = 1'b1;
               w_done_nxt  = (r_word_cnt == 4'd0);
            end
         end
         WRITE: begin
            if (r_word_cnt == 4'd0) begin
               w_state_nxt = IDLE;
            end else begin
               w_ctr_inc   = 1'b1;
               w_state_nxt = LOW;
            end
         end
         DRAIN: begin
            if (w_accept && (r_drain_cnt == 6'd1)) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_ready     <= 1'b0;
         r_word_cnt  <= '0;
         r_drain_cnt <= '0;
         r_lo_byte   <= '0;
         r_d_out     <= '0;
         r_waddr     <= '0;
         r_wen       <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // Ready is registered from the next state, so it drops exactly on WRITE.
         r_ready <= (w_state_nxt != WRITE);
         r_wen   <= w_wen_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         if (w_ctr_load) r_word_cnt <= w_hdr_cnt;
         else if (w_ctr_inc) r_word_cnt <= r_word_cnt - 4'd1;
         if ((r_state == IDLE) && w_accept && !w_hdr_ok)
            r_drain_cnt <= {1'b0, w_hdr_cnt, 1'b0} + 6'd2;
         else if ((r_state == DRAIN) && w_accept)
            r_drain_cnt <= r_drain_cnt - 6'd1;
         if ((r_state == LOW) && w_accept) r_lo_byte <= byte_in;
         if (w_wen_nxt) begin
            r_d_out <= {byte_in, r_lo_byte};
            r_waddr <= w_ctr_addr;
         end
      end
   end

   assign byte_ready = r_ready;
   assign wen_out    = r_wen;
   assign waddr_out  = r_waddr;
   assign d_out      = r_d_out;
   assign busy       = (r_state != IDLE);
   assign frame_done = r_done;
   assign err        = r_err;

   a_addr_wrap: assert property (@(posedge clock) disable iff (reset)
      (w_ctr_inc && w_addr_wrap) |=> (w_ctr_addr == '0));

endmodule

// File: tb/tb_reg_file_loader.sv
// Scoreboard bench for reg_file_loader: expected writes are queued as the
// high byte of each word is driven and popped on every wen_out pulse.
module tb_reg_file_loader;

   localparam int NUM_REGS = 2;
   localparam int ADDR_W   = 1;

   logic              reset;
   logic              clock;
   logic              byte_valid;
   logic [7:0]        byte_in;
   logic              byte_ready;
   logic              wen_out;
   logic [ADDR_W-1:0] waddr_out;
   logic [15:0]       d_out;
   logic              busy;
   logic              frame_done;
   logic              err;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
      logic              done;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  n_wen    = 0;
   int  n_err    = 0;
   int  n_push   = 0;

   reg_file_loader #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) dut (
      .reset      (reset),
      .clock      (clock),
      .byte_valid (byte_valid),
      .byte_in    (byte_in),
      .byte_ready (byte_ready),
      .wen_out    (wen_out),
      .waddr_out  (waddr_out),
      .d_out      (d_out),
      .busy       (busy),
      .frame_done (frame_done),
      .err        (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(negedge clock) begin
      wr_t e;
      if (!reset) begin
         if (busy) chk("ready_low_only_in_write", byte_ready, !wen_out);
         if (frame_done && !wen_out) chk("done_without_wen", wen_out, 1);
         if (err) n_err++;
         if (wen_out) begin
            n_wen++;
            if (exp_q.size() == 0) begin
               chk("wen_with_empty_queue", n_wen, n_push);
            end else begin
               e = exp_q.pop_front();
               chk("waddr", waddr_out, e.addr);
               chk("wdata", d_out, e.data);
               chk("frame_done", frame_done, e.done);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_byte(input logic [7:0] b, output int waits);
      waits      = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (!byte_ready && waits < 50) begin
         @(negedge clock);
         waits++;
      end
      if (waits >= 50) chk("accept_timeout", waits, 0);
      @(negedge clock);
      byte_valid = 1'b0;
      byte_in    = 8'($urandom_range(0, 255));
   endtask

   task automatic send_hdr(input logic [7:0] h, input int gap);
      int w;
      send_byte(h, w);
      repeat (gap) @(negedge clock);
   endtask

   task automatic send_word(input logic [7:0] lo, input logic [7:0] hi,
                            input logic [ADDR_W-1:0] addr, input logic done, input int gap);
      int  w;
      wr_t e;
      send_byte(lo, w);
      repeat (gap) @(negedge clock);
      e.addr = addr;
      e.data = {hi, lo};
      e.done = done;
      exp_q.push_back(e);
      n_push++;
      send_byte(hi, w);
      chk("wen_latency", wen_out, 1);
      repeat (gap) @(negedge clock);
   endtask

   initial begin
      int w;
      reset      = 1'b1;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      #1;
      chk("rst_byte_ready", byte_ready, 0);
      chk("rst_wen", wen_out, 0);
      chk("rst_waddr", waddr_out, 0);
      chk("rst_d_out", d_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_err", err, 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Single-word frame
      send_hdr(8'h00, 0);
      send_word(8'hCD, 8'hAB, 1'b0, 1'b1, 0);
      chk("t1_busy_in_write", busy, 1);
      @(negedge clock);
      chk("t1_busy_after", busy, 0);

      // Three words starting at addr 1 with wrap
      send_hdr(8'h21, 0);
      send_word(8'h11, 8'h11, 1'b1, 1'b0, 0);
      send_word(8'h22, 8'h22, 1'b0, 1'b0, 0);
      send_word(8'h33, 8'h33, 1'b1, 1'b1, 0);
      @(negedge clock);

      // byte_valid toggling every cycle
      send_hdr(8'h10, 1);
      send_word(8'hAA, 8'hBB, 1'b0, 1'b0, 1);
      send_word(8'hCC, 8'hDD, 1'b1, 1'b1, 1);
      @(negedge clock);
      chk("t3_wen_count", n_wen, 6);

      // Out-of-range start address is drained without writes
      send_byte(8'h15, w);
      chk("t4_err_pulse", err, 1);
      chk("t4_busy_drain", busy, 1);
      send_byte(8'h01, w);
      chk("t4_err_one_cycle", err, 0);
      send_byte(8'h02, w);
      send_byte(8'h03, w);
      send_byte(8'h04, w);
      chk("t4_idle_after_drain", busy, 0);
      chk("t4_no_writes", n_wen, 6);
      send_hdr(8'h01, 0);
      send_word(8'h12, 8'h34, 1'b1, 1'b1, 0);
      @(negedge clock);

      // Reset in the middle of a word
      send_hdr(8'h00, 0);
      send_byte(8'h55, w);
      reset = 1'b1;
      #1;
      chk("mid_rst_byte_ready", byte_ready, 0);
      chk("mid_rst_wen", wen_out, 0);
      chk("mid_rst_waddr", waddr_out, 0);
      chk("mid_rst_d_out", d_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_frame_done", frame_done, 0);
      chk("mid_rst_err", err, 0);
      @(negedge clock);
      reset = 1'b0;
      send_hdr(8'h00, 0);
      send_word(8'h66, 8'h77, 1'b0, 1'b1, 0);

      // Back-to-back frames with byte_valid held high
      send_hdr(8'h00, 0);
      send_word(8'h01, 8'h02, 1'b0, 1'b1, 0);
      send_byte(8'h01, w);
      chk("t6_hdr2_wait_cycles", w, 1);
      send_word(8'h03, 8'h04, 1'b1, 1'b1, 0);
      repeat (2) @(negedge clock);

      chk("queue_empty", exp_q.size(), 0);
      chk("wen_total", n_wen, n_push);
      chk("err_total", n_err, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
